// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key map and column reset pattern.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Nibble {row,col} holds the hex code of that key; row 3 carries * as E and # as F.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base;
        base = {row, col, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rows);
        if (!rows[0]) return 2'd0;
        if (!rows[1]) return 2'd1;
        if (!rows[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; idles at all-high (no key).
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] row_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= row_i;
            sync_q <= meta_q;
        end
    end

    assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debouncing and hex key encoding.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS       = 12000,
    parameter int DEBOUNCE_SAMPLES = 5,
    parameter int CNT_W            = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MW = $clog2(DEBOUNCE_SAMPLES + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [1:0]       col_sel_q, col_sel_d;
    logic [1:0]       row_q, row_d;
    logic [MW-1:0]    match_q, match_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic [3:0] rs;
    logic       sample;
    logic       count_done;

    keypad_row_sync u_row_sync (
        .clk   (clk),
        .rst   (rst),
        .row_i (row_in),
        .row_o (rs)
    );

    // Samples land on the last tick of each slot so the column and synchroniser have settled.
    assign sample     = (tick_q == CNT_W'(SCAN_TICKS - 1));
    assign count_done = (match_q == MW'(DEBOUNCE_SAMPLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            tick_q      <= '0;
            col_n_q     <= COL_RESET;
            col_sel_q   <= 2'd0;
            row_q       <= 2'd0;
            match_q     <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            col_n_q     <= col_n_d;
            col_sel_q   <= col_sel_d;
            row_q       <= row_d;
            match_q     <= match_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = sample ? '0 : tick_q + CNT_W'(1);
        col_n_d     = col_n_q;
        col_sel_d   = col_sel_q;
        row_d       = row_q;
        match_d     = match_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (rs == 4'hF) begin
                        col_n_d   = {col_n_q[2:0], col_n_q[3]};
                        col_sel_d = col_sel_q + 2'd1;
                    end else begin
                        row_d   = low_row(rs);
                        match_d = MW'(1);
                        state_d = DEBOUNCE;
                    end
                end
            end

            DEBOUNCE: begin
                if (count_done) begin
                    key_code_d  = key_map(row_q, col_sel_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    match_d     = '0;
                    state_d     = PRESSED;
                end else if (sample) begin
                    if (!rs[row_q]) begin
                        match_d = match_q + MW'(1);
                    end else begin
                        match_d   = '0;
                        col_n_d   = {col_n_q[2:0], col_n_q[3]};
                        col_sel_d = col_sel_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
            end

            PRESSED: begin
                // Only the accepted key's row is watched, so other keys cannot disturb the hold.
                if (count_done) begin
                    key_held_d = 1'b0;
                    match_d    = '0;
                    tick_d     = '0;
                    col_n_d    = {col_n_q[2:0], col_n_q[3]};
                    col_sel_d  = col_sel_q + 2'd1;
                    state_d    = SCAN;
                end else if (sample) begin
                    match_d = rs[row_q] ? match_q + MW'(1) : '0;
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model shorts pressed rows to the driven column.
module tb_keypad_scanner;

    localparam int ST  = 4;
    localparam int DS  = 3;
    localparam int LAT = (DS - 1) * ST + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    bit pressed [4][4];
    int cyc;
    int passed = 0;
    int total  = 0;

    int KEYS [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_TICKS       (ST),
        .DEBOUNCE_SAMPLES (DS),
        .CNT_W            (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && col_n[c] == 1'b0) row_in[r] = 1'b0;
    end

    // Edges since the last edge that saw reset high.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pressed[r][c] = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] col_pattern(input int c);
        logic [3:0] p;
        bit   [1:0] idx;
        idx    = 2'(c);
        p      = 4'hF;
        p[idx] = 1'b0;
        return p;
    endfunction

    // Uninterrupted scan from reset: slot m covers column (m-1)%4 and samples at edge m*ST,
    // seeing the row level the synchroniser captured two edges earlier.
    function automatic int detect_edge(input int c, input int p);
        for (int m = 1; m < 64; m++)
            if ((m - 1) % 4 == c && m * ST - 2 >= p + 1) return m * ST;
        return -1;
    endfunction

    function automatic int first_sample_at_or_after(input int e);
        return ((e + ST - 1) / ST) * ST;
    endfunction

    task automatic test_reset();
        clear_keys();
        rst = 1'b1;
        step();
        step();
        total++; if (col_n !== 4'b1110) $display("[TB] FAIL reset_col_n: got %b expected %b", col_n, 4'b1110); else passed++;
        total++; if (key_code !== 4'h0) $display("[TB] FAIL reset_key_code: got %h expected %h", key_code, 4'h0); else passed++;
        total++; if (key_valid !== 1'b0) $display("[TB] FAIL reset_key_valid: got %b expected 0", key_valid); else passed++;
        total++; if (key_held !== 1'b0) $display("[TB] FAIL reset_key_held: got %b expected 0", key_held); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        int pulses;
        int code_bad;
        pulses   = 0;
        code_bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            total++;
            if (col_n !== col_pattern((cyc / ST) % 4))
                $display("[TB] FAIL idle_col_n at cycle %0d: got %b expected %b", cyc, col_n, col_pattern((cyc / ST) % 4));
            else passed++;
            if (key_valid !== 1'b0) pulses++;
            if (key_code !== 4'h0) code_bad++;
        end
        total++; if (pulses != 0) $display("[TB] FAIL idle_no_pulse: got %0d pulses expected 0", pulses); else passed++;
        total++; if (code_bad != 0) $display("[TB] FAIL idle_key_code: got %0d nonzero cycles expected 0", code_bad); else passed++;
    endtask

    task automatic test_press_release();
        for (int it = 0; it < 7; it++) begin
            int r, c, p, hold, det, pulse_at, n_pulses, first_pulse, frozen_bad, rel, drop;
            logic [3:0] exp_code;
            if (it == 0) begin
                r = 1; c = 2; p = 0; hold = 40;
            end else begin
                r    = int'($urandom_range(3, 0));
                c    = int'($urandom_range(3, 0));
                p    = int'($urandom_range(15, 0));
                hold = int'($urandom_range(50, 10));
            end
            clear_keys();
            apply_reset();
            while (cyc < p) step();
            pressed[r][c] = 1'b1;
            det         = detect_edge(c, p);
            pulse_at    = det + LAT;
            exp_code    = 4'(KEYS[r][c]);
            n_pulses    = 0;
            first_pulse = -1;
            frozen_bad  = 0;
            while (cyc < pulse_at + hold) begin
                step();
                if (key_valid === 1'b1) begin
                    n_pulses++;
                    if (first_pulse < 0) first_pulse = cyc;
                end
                if (cyc > pulse_at && (col_n !== col_pattern(c) || key_held !== 1'b1)) frozen_bad++;
            end
            total++; if (n_pulses != 1) $display("[TB] FAIL press%0d_pulse_count: got %0d expected 1", it, n_pulses); else passed++;
            total++; if (first_pulse != pulse_at) $display("[TB] FAIL press%0d_pulse_cycle: got %0d expected %0d", it, first_pulse, pulse_at); else passed++;
            total++; if (key_code !== exp_code) $display("[TB] FAIL press%0d_key_code: got %h expected %h", it, key_code, exp_code); else passed++;
            total++; if (key_held !== 1'b1) $display("[TB] FAIL press%0d_key_held: got %b expected 1", it, key_held); else passed++;
            total++; if (col_n !== col_pattern(c)) $display("[TB] FAIL press%0d_col_frozen: got %b expected %b", it, col_n, col_pattern(c)); else passed++;
            total++; if (frozen_bad != 0) $display("[TB] FAIL press%0d_hold_stable: got %0d bad cycles expected 0", it, frozen_bad); else passed++;

            rel = cyc;
            pressed[r][c] = 1'b0;
            drop = first_sample_at_or_after(rel + 3) + (DS - 1) * ST + 1;
            while (cyc < drop - 1) step();
            total++; if (key_held !== 1'b1) $display("[TB] FAIL release%0d_held_before: got %b expected 1", it, key_held); else passed++;
            step();
            total++; if (key_held !== 1'b0) $display("[TB] FAIL release%0d_held_drop: got %b expected 0", it, key_held); else passed++;
            total++; if (col_n !== col_pattern((c + 1) % 4)) $display("[TB] FAIL release%0d_col_resume: got %b expected %b", it, col_n, col_pattern((c + 1) % 4)); else passed++;
            total++; if (key_code !== exp_code) $display("[TB] FAIL release%0d_code_kept: got %h expected %h", it, key_code, exp_code); else passed++;
        end
    endtask

    task automatic test_bounce();
        int n_pulses, first_pulse, code_bad;
        n_pulses    = 0;
        first_pulse = -1;
        code_bad    = 0;
        clear_keys();
        apply_reset();
        pressed[3][0] = 1'b1;
        while (cyc < 5) step();
        pressed[3][0] = 1'b0;
        while (cyc < 7) step();
        total++; if (col_n !== 4'b1110) $display("[TB] FAIL bounce_col_frozen: got %b expected %b", col_n, 4'b1110); else passed++;
        step();
        total++; if (col_n !== 4'b1101) $display("[TB] FAIL bounce_abort_advance: got %b expected %b", col_n, 4'b1101); else passed++;
        step();
        pressed[3][0] = 1'b1;
        // After the abort, column 0 comes round again in the slot sampled at edge 24.
        while (cyc < 60) begin
            step();
            if (key_valid === 1'b1) begin
                n_pulses++;
                if (first_pulse < 0) first_pulse = cyc;
            end
            if (cyc < 24 + LAT && key_code !== 4'h0) code_bad++;
        end
        total++; if (n_pulses != 1) $display("[TB] FAIL bounce_pulse_count: got %0d expected 1", n_pulses); else passed++;
        total++; if (first_pulse != 24 + LAT) $display("[TB] FAIL bounce_pulse_cycle: got %0d expected %0d", first_pulse, 24 + LAT); else passed++;
        total++; if (code_bad != 0) $display("[TB] FAIL bounce_no_early_code: got %0d bad cycles expected 0", code_bad); else passed++;
        total++; if (key_code !== 4'hE) $display("[TB] FAIL bounce_key_code: got %h expected %h", key_code, 4'hE); else passed++;
        pressed[3][0] = 1'b0;
    endtask

    task automatic test_priority();
        int p, det, n_pulses, first_pulse, late_pulses, frozen_bad;
        p           = int'($urandom_range(6, 0));
        n_pulses    = 0;
        first_pulse = -1;
        late_pulses = 0;
        frozen_bad  = 0;
        clear_keys();
        apply_reset();
        while (cyc < p) step();
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        det = detect_edge(3, p);
        while (cyc < det + LAT + 2) begin
            step();
            if (key_valid === 1'b1) begin
                n_pulses++;
                if (first_pulse < 0) first_pulse = cyc;
            end
        end
        total++; if (first_pulse != det + LAT) $display("[TB] FAIL prio_pulse_cycle: got %0d expected %0d", first_pulse, det + LAT); else passed++;
        total++; if (key_code !== 4'(KEYS[0][3])) $display("[TB] FAIL prio_key_code: got %h expected %h", key_code, 4'(KEYS[0][3])); else passed++;
        pressed[1][1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (key_valid === 1'b1) late_pulses++;
            if (col_n !== col_pattern(3) || key_held !== 1'b1) frozen_bad++;
        end
        total++; if (n_pulses + late_pulses != 1) $display("[TB] FAIL prio_second_key_pulses: got %0d expected 1", n_pulses + late_pulses); else passed++;
        total++; if (frozen_bad != 0) $display("[TB] FAIL prio_hold_stable: got %0d bad cycles expected 0", frozen_bad); else passed++;
        total++; if (key_code !== 4'hA) $display("[TB] FAIL prio_code_kept: got %h expected %h", key_code, 4'hA); else passed++;
        clear_keys();
    endtask

    task automatic test_reset_pressed();
        int n_pulses, first_pulse;
        n_pulses    = 0;
        first_pulse = -1;
        clear_keys();
        apply_reset();
        pressed[2][1] = 1'b1;
        while (cyc < 25) step();
        total++; if (key_held !== 1'b1) $display("[TB] FAIL rstp_held_before: got %b expected 1", key_held); else passed++;
        total++; if (key_code !== 4'h8) $display("[TB] FAIL rstp_code_before: got %h expected %h", key_code, 4'h8); else passed++;
        rst = 1'b1;
        pressed[2][1] = 1'b0;
        step();
        total++; if (col_n !== 4'b1110) $display("[TB] FAIL rstp_col_n: got %b expected %b", col_n, 4'b1110); else passed++;
        total++; if (key_held !== 1'b0) $display("[TB] FAIL rstp_key_held: got %b expected 0", key_held); else passed++;
        total++; if (key_code !== 4'h0) $display("[TB] FAIL rstp_key_code: got %h expected 0", key_code); else passed++;
        total++; if (key_valid !== 1'b0) $display("[TB] FAIL rstp_key_valid: got %b expected 0", key_valid); else passed++;
        rst = 1'b0;
        while (cyc < 2) step();
        pressed[3][2] = 1'b1;
        while (cyc < detect_edge(2, 2) + LAT + 4) begin
            step();
            if (key_valid === 1'b1) begin
                n_pulses++;
                if (first_pulse < 0) first_pulse = cyc;
            end
        end
        total++; if (n_pulses != 1) $display("[TB] FAIL rstp_new_pulses: got %0d expected 1", n_pulses); else passed++;
        total++; if (first_pulse != detect_edge(2, 2) + LAT) $display("[TB] FAIL rstp_new_cycle: got %0d expected %0d", first_pulse, detect_edge(2, 2) + LAT); else passed++;
        total++; if (key_code !== 4'hF) $display("[TB] FAIL rstp_new_code: got %h expected %h", key_code, 4'hF); else passed++;
        clear_keys();
    endtask

    initial begin
        clear_keys();
        test_reset();
        test_idle_scan();
        test_press_release();
        test_bounce();
        test_priority();
        test_reset_pressed();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, debounces presses and releases, and encodes the pressed key as a 4-bit hex code.
- Sits directly upstream of the seven-segment decoder: key_code drives the decoder's 4-bit input.
- key_valid and key_held let other logic detect new keystrokes.
- Targets the MAX1000 12 MHz board clock.

Parameters:
- SCAN_TICKS, 12000, clock cycles each column stays driven (1 ms at 12 MHz). Minimum 4.
- DEBOUNCE_SAMPLES, 5, consecutive matching samples needed to accept a press or a release. Minimum 2.
- CNT_W, 16, width of the tick counter. Must hold SCAN_TICKS-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- row_in  input  4  keypad rows, pulled up externally; low means a key in the driven column is closed.
- col_n  output  4  column drive, active-low, one-hot-low.
- key_code  output  4  last accepted key code; held until the next accepted press.
- key_valid  output  1  one-cycle pulse when a new debounced press is accepted.
- key_held  output  1  high from acceptance until the release is accepted.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high on clk.
- Reset values: col_n=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters 0.
- Row synchronisation:
  - row_in passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
  - A sample is taken on the last tick of each SCAN_TICKS slot (tick counter == SCAN_TICKS-1). This gives the column settle time plus synchroniser delay.
- SCAN state:
  - At each sample, if rs == 4'hF, rotate col_n left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110) and reset the tick counter.
  - If any rs bit is low, capture the column index c and the lowest-index low row r (priority to row 0), set the match count to 1, freeze col_n, and go to DEBOUNCE.
- DEBOUNCE state:
  - At each sample, if rs[r] is low, increment the match count; otherwise return to SCAN and advance the column.
  - When the match count reaches DEBOUNCE_SAMPLES, then on the next cycle: key_code <= map(r,c), key_valid=1 for exactly one cycle, key_held=1, go to PRESSED.
- PRESSED state:
  - col_n stays frozen on column c.
  - At each sample, rs[r] high increments the release count; rs[r] low clears it.
  - When the release count reaches DEBOUNCE_SAMPLES: key_held=0, go to SCAN, advance the column.
  - Other keys pressed meanwhile are ignored (no rollover).
- Key map (row, columns 0..3):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E (*), 0, F (#), D
- Latency: key_valid asserts (DEBOUNCE_SAMPLES-1)*SCAN_TICKS+1 cycles after the detecting sample.
- Boundary conditions:
  - A bounce during DEBOUNCE aborts with no output change.
  - Multiple rows low in one column: lowest row wins.
  - Keys in different columns pressed at once: the first column reached in scan order wins.
  - rst mid-DEBOUNCE or mid-PRESSED: immediate return to reset values next cycle, and key_code clears to 0.
  - The tick counter wraps at SCAN_TICKS-1 with no skipped or duplicated samples.
  - A key held indefinitely produces no repeat key_valid.

Decomposition:
- Package keypad_pkg holds:
  - state encoding (SCAN, DEBOUNCE, PRESSED as 2-bit localparams);
  - the 16-entry key map constant indexed by {row, col};
  - the reset column pattern 4'b1110.
- One sub-module: keypad_row_sync, a 4-bit, 2-flop synchroniser with synchronous reset to 4'hF.
- The FSM, counters and column rotation stay in keypad_scanner.

Test Plan (SCAN_TICKS=4, DEBOUNCE_SAMPLES=3, keypad model shorts row to the driven column):
- Reset then idle 100 cycles -> col_n cycles 1110, 1101, 1011, 0111, changing every 4 cycles; key_valid never asserts; key_code=0.
- Clean press at row1/col2 held 40 cycles -> key_valid single pulse 9 cycles after the first detecting sample; key_code=4'h6; key_held=1; col_n frozen at 1011.
- Release of that key -> key_held drops 1 cycle after the 3rd consecutive high sample; scanning resumes at 0111; key_code stays 4'h6.
- Bouncing press at row3/col0 (low 5 cycles, high 4, then low steady) -> first attempt aborts with no pulse; later acceptance gives key_code=4'hE with exactly one key_valid.
- Row0 and row2 pressed in col3 together -> key_code=4'hA (row 0 priority); a second key pressed while held gives no new pulse.
- rst asserted during PRESSED -> next cycle col_n=1110, key_held=0, key_code=0, key_valid=0; a new press is accepted normally afterwards.
